// File: rtl/adder_16bit_accumulator.sv
// adder_16bit_accumulator: collects NUM_SAMPLES unsigned 16-bit samples over a
// valid/ready input, sums them through a single adder_16bit, and presents the
// total and a sticky carry-out flag on a valid/ready output.
// Optional build macro: ACCUM_SATURATE_EN clamps the running sum at 16'hFFFF
// on carry-out instead of wrapping.

// 16-bit unsigned adder with carry-out of bit 15 reported as overflow.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        overflow
);
  logic [16:0] w_full;

  assign w_full   = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};
  assign sum      = w_full[15:0];
  assign overflow = w_full[16];
endmodule

module adder_16bit_accumulator #(
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] result,
  output logic        result_overflow,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(NUM_SAMPLES);
  localparam logic [CNT_WIDTH-1:0] LP_ONE  = CNT_WIDTH'(1);

  state_t               r_state;
  logic [15:0]          r_acc;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_ovf_sticky;
  logic [15:0]          r_result;
  logic                 r_result_overflow;
  logic                 r_result_valid;

  logic [15:0]          w_adder_a;
  logic [15:0]          w_sum;
  logic                 w_ovf;
  logic [15:0]          w_acc_next;
  logic                 w_sticky_next;
  logic                 w_last;
  logic                 w_accept;

  // The first sample of a frame is loaded by adding it to zero, so the
  // adder remains the only arithmetic path into the accumulator.
  assign w_adder_a = (r_state == ST_IDLE) ? 16'd0 : r_acc;

  adder_16bit u_adder (
    .a        (w_adder_a),
    .b        (in_data),
    .carry_in (1'b0),
    .sum      (w_sum),
    .overflow (w_ovf)
  );

  assign in_ready = (r_state != ST_DONE);
  assign busy     = (r_state != ST_IDLE);
  assign w_accept = in_valid & in_ready;

  // Next accumulator value, sticky flag and end-of-frame detection.
  always_comb begin
    w_acc_next    = w_sum;
    w_sticky_next = 1'b0;
    w_last        = 1'b0;
`ifdef ACCUM_SATURATE_EN
    if (w_ovf) begin
      w_acc_next = 16'hFFFF;
    end
`endif
    if (r_state == ST_IDLE) begin
      w_sticky_next = 1'b0;
      w_last        = (NUM_SAMPLES == 1);
    end else begin
      w_sticky_next = r_ovf_sticky | w_ovf;
      w_last        = ((r_count + LP_ONE) == LP_LAST);
    end
  end

  // Frame state machine; clear aborts a frame but keeps the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_acc             <= 16'd0;
      r_count           <= '0;
      r_ovf_sticky      <= 1'b0;
      r_result          <= 16'd0;
      r_result_overflow <= 1'b0;
      r_result_valid    <= 1'b0;
    end else if (clear) begin
      r_state        <= ST_IDLE;
      r_acc          <= 16'd0;
      r_count        <= '0;
      r_ovf_sticky   <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_accept) begin
            r_acc        <= w_acc_next;
            r_ovf_sticky <= w_sticky_next;
            r_count      <= (r_state == ST_IDLE) ? LP_ONE : (r_count + LP_ONE);
            if (w_last) begin
              r_state           <= ST_DONE;
              r_result          <= w_acc_next;
              r_result_overflow <= w_sticky_next;
              r_result_valid    <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_DONE: begin
          if (r_result_valid && result_ready) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
            r_acc          <= 16'd0;
            r_count        <= '0;
            r_ovf_sticky   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign result          = r_result;
  assign result_overflow = r_result_overflow;
  assign result_valid    = r_result_valid;
endmodule

// File: tb/tb_adder_16bit_accumulator.sv
// Directed bench for adder_16bit_accumulator with NUM_SAMPLES=4.
`timescale 1ns/1ps
module tb_adder_16bit_accumulator;
  logic        clk;
  logic        rst;
  logic        clear;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] result;
  logic        result_overflow;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  int n_cmp;
  int n_err;

  adder_16bit_accumulator #(.NUM_SAMPLES(4), .CNT_WIDTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .result          (result),
    .result_overflow (result_overflow),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Present one sample for exactly one rising edge.
  task automatic push(input logic [15:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Last push was just made: result must already be valid; check it and retire it.
  task automatic take(input string tag, input logic [15:0] exp_res, input logic exp_ovf);
    check_val({tag, " valid"}, {31'd0, result_valid}, 32'd1);
    check_val({tag, " result"}, {16'd0, result}, {16'd0, exp_res});
    check_val({tag, " ovf"}, {31'd0, result_overflow}, {31'd0, exp_ovf});
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check_val({tag, " idle after hs"}, {30'd0, result_valid, in_ready}, 32'd1);
  endtask

  logic [15:0] exp_ovf_res;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; clear = 1'b0; in_data = '0; in_valid = 1'b0; result_ready = 1'b0;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);
    check_val("reset state", {13'd0, result_overflow, result_valid, busy}, 32'd0);
    check_val("reset result", {16'd0, result}, 32'd0);
    check_val("reset in_ready", {31'd0, in_ready}, 32'd1);

    // Async reset mid-cycle while a frame is in progress.
    push(16'd3);
    push(16'd3);
    check_val("busy mid frame", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async rst busy", {31'd0, busy}, 32'd0);
    check_val("async rst valid", {31'd0, result_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst release in_ready", {31'd0, in_ready}, 32'd1);
    push(16'd1); push(16'd2); push(16'd3);
    check_val("no early valid", {31'd0, result_valid}, 32'd0);
    push(16'd4);
    take("frame 1234", 16'd10, 1'b0);

    // Overflow: FFFF + 2 carries out.
`ifdef ACCUM_SATURATE_EN
    exp_ovf_res = 16'hFFFF;
`else
    exp_ovf_res = 16'h0001;
`endif
    push(16'hFFFF); push(16'h0002); push(16'h0000); push(16'h0000);
    take("overflow", exp_ovf_res, 1'b1);

    // Backpressure: result held while downstream stalls, no sample consumed.
    push(16'd100); push(16'd200); push(16'd300); push(16'd400);
    in_data  = 16'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("stall%0d res", i), {15'd0, result_valid, result}, {16'd1, 16'd1000});
      check_val($sformatf("stall%0d rdy", i), {31'd0, in_ready}, 32'd0);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check_val("bp handshake idle", {30'd0, busy, result_valid}, 32'd0);
    push(16'd7); push(16'd7); push(16'd7); push(16'd7);
    take("frame 7x4", 16'd28, 1'b0);

    // Bubbles between samples.
    push(16'd5);
    idle_cycles(3);
    push(16'd5);
    idle_cycles(1);
    push(16'd5);
    check_val("bubble no valid", {30'd0, busy, result_valid}, 32'd2);
    push(16'd5);
    take("bubbles", 16'd20, 1'b0);

    // Clear with a sample offered in the same cycle.
    push(16'd9); push(16'd9);
    clear = 1'b1; in_data = 16'd50; in_valid = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    check_val("clear idle", {30'd0, busy, result_valid}, 32'd0);
    check_val("clear keeps result", {16'd0, result}, 32'd20);
    push(16'd1); push(16'd1); push(16'd1); push(16'd1);
    take("after clear", 16'd4, 1'b0);

    // Reset mid-frame discards sticky overflow.
    push(16'h8000); push(16'h8000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_val("midrst outputs", {15'd0, result_overflow, result_valid, result[14:0]}, 32'd0);
    push(16'd0); push(16'd0); push(16'd0); push(16'd0);
    take("zeros", 16'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
